// File: rtl/ccd_pkg.sv
// ccd_pkg
// Shared types and constants for the CCD pixel capture slice.
//   capState_e  : capture FSM states (IDLE, SKIP, ACTIVE)
//   DARK_AVG_N  : number of trailing dummy pixels averaged for the dark level
//   DARK_SHIFT  : log2(DARK_AVG_N), turns the dark sum into an average
//   PIX_W       : storage width of the data field in a pixel entry (ADC_W <= PIX_W)
//   pixEntry_t  : one buffered pixel {data, first, last}
package ccd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    ACTIVE = 2'd2
  } capState_e;

  localparam int DARK_AVG_N = 16;
  localparam int DARK_SHIFT = 4;

  // Data field is sized for the widest supported ADC; narrower samples are
  // zero-extended on the way in and truncated on the way out.
  localparam int PIX_W = 16;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             first;
    logic             last;
  } pixEntry_t;

endpackage

// File: rtl/ccd_sync_fifo.sv
// ccd_sync_fifo
// Single-clock FIFO with synchronous active-high reset (flushes contents).
// Read data is presented combinationally from the head entry (first-word
// fall-through), so rdata_o is valid whenever empty_o is low.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data
//   pop_i             : read request (ignored while empty)
//   rdata_o           : head entry
//   full_o, empty_o   : occupancy status
module ccd_sync_fifo
  import ccd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rdata_o = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO may proceed.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/ccd_pixel_capture.sv
// ccd_pixel_capture
// Receive side of the CCD driver: detects the line-start (SH) and pixel strobe
// rising edges, discards the leading dummy pixels of each line, and streams the
// active pixels through a small FIFO as valid/ready with first/last framing.
// Optional build macro DARK_SUB_EN: averages the last 16 dummy pixels of each
// line and subtracts that dark level (saturating at 0) from every active pixel,
// at the cost of one extra pipeline stage.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   line_start, pixel_strobe : SH and pixel_ready from the driver (edge events)
//   adc_data                 : ADC sample, stable on the strobe rising edge
//   arm                      : new lines are only captured while high
//   out_data/valid/ready     : pixel stream, out_first/out_last frame a line
//   line_done                : one-cycle pulse after the last active pixel push
//   overflow, line_err       : sticky flags, cleared by clear_flags
//   busy                     : capture FSM is not IDLE
module ccd_pixel_capture
  import ccd_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int DUMMY_PIX  = 32,
  parameter int ACTIVE_PIX = 3648,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_start,
  input  logic             pixel_strobe,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             arm,
  output logic [ADC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             line_done,
  output logic             overflow,
  output logic             line_err,
  input  logic             clear_flags,
  output logic             busy
);

  localparam int MAX_PIX = (DUMMY_PIX > ACTIVE_PIX) ? DUMMY_PIX : ACTIVE_PIX;
  localparam int CNT_W   = $clog2(MAX_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY  = CNT_W'(DUMMY_PIX - 1);
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE_PIX - 1);

  capState_e        state_q, state_d;
  logic [CNT_W-1:0] pixCnt_q, pixCnt_d;
  logic             lineStartPrev_q, strobePrev_q;
  logic             lineEdge, strobeEdge;
  logic             s1Valid_q, s1Valid_d;
  pixEntry_t        s1Entry_q, s1Entry_d;
  logic             pushValid;
  pixEntry_t        pushEntry;
  pixEntry_t        rdEntry;
  logic             fifoFull, fifoEmpty, popFire;
  logic             errSet, overflowSet;
  logic             overflow_q, lineErr_q, lineDone_q;
  logic             unusedDataBits;

`ifdef DARK_SUB_EN
  localparam logic [CNT_W-1:0] DARK_FIRST = CNT_W'(DUMMY_PIX - DARK_AVG_N);
  logic                   accClr, accAdd, darkLatch;
  logic [ADC_W+3:0]       darkAcc_q;
  logic [ADC_W+3:0]       darkSum;
  logic [ADC_W-1:0]       darkVal_q;
  logic [ADC_W-1:0]       rawPix;
  logic                   s2Valid_q;
  pixEntry_t              s2Entry_q, s2Entry_d;
`endif

  // Previous-cycle copies of the driver outputs; inputs share our clock so
  // no synchroniser is needed, only the rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      lineStartPrev_q <= 1'b0;
      strobePrev_q    <= 1'b0;
    end else begin
      lineStartPrev_q <= line_start;
      strobePrev_q    <= pixel_strobe;
    end
  end

  // A strobe coinciding with a line start belongs to no line and is dropped.
  assign lineEdge   = line_start & ~lineStartPrev_q;
  assign strobeEdge = pixel_strobe & ~strobePrev_q & ~lineEdge;

  // Capture FSM state and pixel counter plus the first pipeline stage that
  // holds the sampled pixel for one cycle before it is pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pixCnt_q  <= '0;
      s1Valid_q <= 1'b0;
      s1Entry_q <= '0;
    end else begin
      state_q   <= state_d;
      pixCnt_q  <= pixCnt_d;
      s1Valid_q <= s1Valid_d;
      s1Entry_q <= s1Entry_d;
    end
  end

  // Next-state logic. A line start always restarts counting; mid-line it also
  // raises line_err and abandons the partial line (queued pixels stay queued).
  // With arm low, a line start only ends the current line and nothing restarts.
  always_comb begin
    state_d   = state_q;
    pixCnt_d  = pixCnt_q;
    s1Valid_d = 1'b0;
    s1Entry_d = '0;
    errSet    = 1'b0;
`ifdef DARK_SUB_EN
    accClr    = 1'b0;
    accAdd    = 1'b0;
    darkLatch = 1'b0;
`endif
    if (lineEdge) begin
      errSet   = (state_q != IDLE);
      pixCnt_d = '0;
      state_d  = arm ? SKIP : IDLE;
`ifdef DARK_SUB_EN
      accClr   = 1'b1;
`endif
    end else if (strobeEdge) begin
      case (state_q)
        SKIP: begin
`ifdef DARK_SUB_EN
          accAdd = (pixCnt_q >= DARK_FIRST);
`endif
          if (pixCnt_q == LAST_DUMMY) begin
            state_d  = ACTIVE;
            pixCnt_d = '0;
`ifdef DARK_SUB_EN
            darkLatch = 1'b1;
`endif
          end else begin
            pixCnt_d = pixCnt_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          s1Valid_d       = 1'b1;
          s1Entry_d.data  = PIX_W'(adc_data);
          s1Entry_d.first = (pixCnt_q == '0);
          s1Entry_d.last  = (pixCnt_q == LAST_ACTIVE);
          if (pixCnt_q == LAST_ACTIVE) begin
            state_d  = IDLE;
            pixCnt_d = '0;
          end else begin
            pixCnt_d = pixCnt_q + CNT_W'(1);
          end
        end
        default: begin
          // Trailing dummy pixels arrive while IDLE and are ignored.
        end
      endcase
    end
  end

`ifdef DARK_SUB_EN
  // The final dummy sample is folded in combinationally so the dark level is
  // ready the cycle after the SKIP->ACTIVE transition. An aborted line never
  // reaches that transition, so it keeps using the previous dark level.
  assign darkSum = darkAcc_q + (ADC_W+4)'(adc_data);

  // Dark accumulator and latched dark level.
  always_ff @(posedge clk) begin
    if (rst) begin
      darkAcc_q <= '0;
      darkVal_q <= '0;
    end else begin
      if (accClr)      darkAcc_q <= '0;
      else if (accAdd) darkAcc_q <= darkSum;
      if (darkLatch)   darkVal_q <= darkSum[ADC_W+3:DARK_SHIFT];
    end
  end

  // Saturating dark subtraction forms the extra pipeline stage.
  assign rawPix = s1Entry_q.data[ADC_W-1:0];

  always_comb begin
    s2Entry_d       = s1Entry_q;
    s2Entry_d.data  = (rawPix > darkVal_q) ? PIX_W'(rawPix - darkVal_q) : '0;
  end

  // Second pipeline stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Entry_q <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      s2Entry_q <= s2Entry_d;
    end
  end

  assign pushValid = s2Valid_q;
  assign pushEntry = s2Entry_q;
  assign unusedDataBits = ^rdEntry.data ^ ^s1Entry_q.data;
`else
  assign pushValid = s1Valid_q;
  assign pushEntry = s1Entry_q;
  assign unusedDataBits = ^rdEntry.data;
`endif

  ccd_sync_fifo #(
    .WIDTH($bits(pixEntry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (pushValid),
    .wdata_i(pushEntry),
    .pop_i  (popFire),
    .rdata_o(rdEntry),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  assign popFire     = out_valid & out_ready;
  assign overflowSet = pushValid & fifoFull & ~popFire;

  // Sticky flags (a new set beats a same-cycle clear) and the line_done pulse,
  // which follows the push attempt of the last active pixel even if dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      lineErr_q  <= 1'b0;
      lineDone_q <= 1'b0;
    end else begin
      overflow_q <= overflowSet | (overflow_q & ~clear_flags);
      lineErr_q  <= errSet | (lineErr_q & ~clear_flags);
      lineDone_q <= pushValid & pushEntry.last;
    end
  end

  // Stream outputs are forced to zero while empty so stale storage never shows.
  assign out_valid = ~fifoEmpty;
  assign out_data  = out_valid ? rdEntry.data[ADC_W-1:0] : '0;
  assign out_first = out_valid & rdEntry.first;
  assign out_last  = out_valid & rdEntry.last;
  assign line_done = lineDone_q;
  assign overflow  = overflow_q;
  assign line_err  = lineErr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// tb_ccd_pixel_capture
// Directed and randomized checks of ccd_pixel_capture with DUMMY_PIX=16,
// ACTIVE_PIX=8, FIFO_DEPTH=4. A line-level reference model turns the list of
// strobed samples of each line into the expected pixel stream.
// Honours DARK_SUB_EN when the design is built with it.
module tb_ccd_pixel_capture;

  localparam int ADC_W  = 12;
  localparam int DUMMY  = 16;
  localparam int ACTIVE = 8;
  localparam int DEPTH  = 4;
`ifdef DARK_SUB_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk;
  logic             rst;
  logic             line_start;
  logic             pixel_strobe;
  logic [ADC_W-1:0] adc_data;
  logic             arm;
  logic [ADC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;
  logic             line_done;
  logic             overflow;
  logic             line_err;
  logic             clear_flags;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;
  int rxQ[$];
  int expQ[$];
  int lineVals[$];
  int doneCnt    = 0;
  int lastDark   = 0;
  int readyMode  = 1;
  int lowRun     = 0;

  ccd_pixel_capture #(
    .ADC_W(ADC_W), .DUMMY_PIX(DUMMY), .ACTIVE_PIX(ACTIVE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .pixel_strobe(pixel_strobe),
    .adc_data(adc_data), .arm(arm), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .line_done(line_done), .overflow(overflow), .line_err(line_err),
    .clear_flags(clear_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted beat and every line_done pulse, mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      rxQ.push_back(int'(out_data) * 4 + (out_first ? 2 : 0) + (out_last ? 1 : 0));
    if (line_done) doneCnt++;
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = random but never low 3 cycles in a row.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: begin
          out_ready = (lowRun >= 2) ? 1'b1 : (($urandom % 3) != 0);
          lowRun    = out_ready ? 0 : lowRun + 1;
        end
      endcase
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, observed no $finish required one");
    $fatal(1, "[TB] stopped by watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel strobe: high for two cycles, then low for gap cycles.
  task automatic applyStimulus(input int value, input int gap);
    adc_data     = ADC_W'(value);
    pixel_strobe = 1'b1;
    lineVals.push_back(value);
    tick(2);
    pixel_strobe = 1'b0;
    tick(gap);
  endtask

  task automatic startLine();
    line_start = 1'b1;
    tick(2);
    line_start = 1'b0;
    tick(1);
    lineVals.delete();
  endtask

  // Reference model: strobe n of a line (0-based) is active when
  // DUMMY <= n < DUMMY+ACTIVE; the dark level is the mean of the 16 samples
  // just before the first active one and persists until a line reaches it.
  task automatic modelLine(input int n);
    int sum;
    int v;
    if (n >= DUMMY) begin
      sum = 0;
      for (int i = DUMMY - 16; i < DUMMY; i++) sum += lineVals[i];
      lastDark = sum / 16;
    end
    for (int i = DUMMY; i < n && i < DUMMY + ACTIVE; i++) begin
      v = lineVals[i];
`ifdef DARK_SUB_EN
      v = (v > lastDark) ? v - lastDark : 0;
`endif
      expQ.push_back(v * 4 + ((i == DUMMY) ? 2 : 0) + ((i == DUMMY + ACTIVE - 1) ? 1 : 0));
    end
  endtask

  task automatic waitDrain();
    int budget;
    budget = 500;
    while (budget > 0 && (rxQ.size() < expQ.size() || out_valid)) begin
      tick(1);
      budget--;
    end
    tick(2);
  endtask

  task automatic checkQueues(input string tag);
    checkOutput($sformatf("%s_count", tag), rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      checkOutput($sformatf("%s_px%0d", tag, i), rxQ[i], expQ[i]);
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    rst = 1'b1; line_start = 1'b0; pixel_strobe = 1'b0; adc_data = '0;
    arm = 1'b0; clear_flags = 1'b0;
    tick(3);
    $display("[TB] reset state");
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_first", out_first, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_done", line_done, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_err", line_err, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    $display("[TB] normal line with latency probe");
    arm = 1'b1; readyMode = 1; doneCnt = 0;
    startLine();
    checkOutput("normal_busy_start", busy, 1);
    for (int i = 0; i < DUMMY; i++) applyStimulus(i, 2);
    adc_data = ADC_W'(DUMMY); pixel_strobe = 1'b1; lineVals.push_back(DUMMY);
    checkOutput("lat_c0", out_valid, 0);
    tick(1);
    checkOutput("lat_c1", out_valid, 0);
    tick(1);
    pixel_strobe = 1'b0;
    checkOutput("lat_c2", out_valid, (LAT == 2) ? 1 : 0);
    tick(1);
    checkOutput("lat_c3", out_valid, (LAT == 3) ? 1 : 0);
    tick(2);
    for (int i = DUMMY + 1; i < DUMMY + ACTIVE; i++) applyStimulus(i, 2);
    modelLine(DUMMY + ACTIVE);
    waitDrain();
    checkQueues("normal");
    checkOutput("normal_done_pulses", doneCnt, 1);
    checkOutput("normal_busy_end", busy, 0);

    $display("[TB] dark-level line");
    startLine();
    for (int i = 0; i < DUMMY; i++) applyStimulus(100, 2);
    for (int i = 0; i < ACTIVE; i++) applyStimulus((i % 2 == 0) ? 150 : 90, 2);
    modelLine(DUMMY + ACTIVE);
    waitDrain();
    checkQueues("dark");

    $display("[TB] backpressure and overflow");
    readyMode = 0;
    tick(3);
    startLine();
    for (int i = 0; i < DUMMY + ACTIVE; i++) applyStimulus(i, 2);
    tick(4);
    checkOutput("bp_overflow", overflow, 1);
    checkOutput("bp_valid_held", out_valid, 1);
    modelLine(DUMMY + ACTIVE);
    while (expQ.size() > DEPTH) void'(expQ.pop_back());
    readyMode = 1;
    waitDrain();
    checkQueues("bp");
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    checkOutput("bp_cleared", overflow, 0);

    $display("[TB] aborted line");
    startLine();
    for (int i = 0; i < DUMMY + 3; i++) applyStimulus(100 + i, 2);
    modelLine(DUMMY + 3);
    checkOutput("abort_err_before", line_err, 0);
    startLine();
    checkOutput("abort_err", line_err, 1);
    checkOutput("abort_busy", busy, 1);
    for (int i = 0; i < DUMMY + ACTIVE; i++) applyStimulus(200 + i, 2);
    modelLine(DUMMY + ACTIVE);
    waitDrain();
    checkQueues("abort");
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    checkOutput("abort_cleared", line_err, 0);

    $display("[TB] line start and strobe in the same cycle");
    startLine();
    for (int i = 0; i < DUMMY + 2; i++) applyStimulus(300 + i, 2);
    modelLine(DUMMY + 2);
    line_start = 1'b1; pixel_strobe = 1'b1; adc_data = ADC_W'(999);
    tick(2);
    line_start = 1'b0; pixel_strobe = 1'b0;
    tick(2);
    lineVals.delete();
    checkOutput("same_err", line_err, 1);
    for (int i = 0; i < DUMMY + ACTIVE; i++) applyStimulus(400 + i, 2);
    modelLine(DUMMY + ACTIVE);
    waitDrain();
    checkQueues("same");

    $display("[TB] reset during active pixels");
    readyMode = 0;
    tick(2);
    startLine();
    for (int i = 0; i < DUMMY + 3; i++) applyStimulus(500 + i, 2);
    tick(3);
    checkOutput("rstmid_valid_before", out_valid, 1);
    checkOutput("rstmid_err_before", line_err, 1);
    rst = 1'b1;
    tick(1);
    checkOutput("rstmid_valid", out_valid, 0);
    checkOutput("rstmid_err", line_err, 0);
    checkOutput("rstmid_ovf", overflow, 0);
    checkOutput("rstmid_busy", busy, 0);
    rst = 1'b0;
    lastDark = 0;
    lineVals.delete();
    readyMode = 1;
    tick(10);
    checkOutput("rstmid_flushed", rxQ.size(), 0);
    rxQ.delete();

    $display("[TB] arm dropped mid-line");
    startLine();
    for (int i = 0; i < 5; i++) applyStimulus(600 + i, 2);
    arm = 1'b0;
    for (int i = 5; i < DUMMY + ACTIVE; i++) applyStimulus(600 + i, 2);
    modelLine(DUMMY + ACTIVE);
    waitDrain();
    checkQueues("arm");
    checkOutput("arm_idle", busy, 0);
    startLine();
    checkOutput("arm_no_line", busy, 0);
    for (int i = 0; i < 4; i++) applyStimulus(700 + i, 2);
    tick(5);
    checkOutput("arm_no_output", rxQ.size(), 0);
    rxQ.delete();
    arm = 1'b1;

    $display("[TB] randomized lines");
    readyMode = 2;
    for (int l = 0; l < 4; l++) begin
      startLine();
      for (int i = 0; i < DUMMY + ACTIVE; i++)
        applyStimulus(int'($urandom_range(0, 4095)), int'($urandom_range(2, 4)));
      modelLine(DUMMY + ACTIVE);
      waitDrain();
      checkQueues($sformatf("rand%0d", l));
    end
    checkOutput("rand_err", line_err, 0);
    checkOutput("rand_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
